lsu_mem_ctrl: RTL

- Load/store sequencer between the execute stage and the data RAM.
- Accepts one memory request at a time over a valid/ready handshake.
- Translates RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into the RAM's native operations: word read, word write, byte write.
- Performs byte-lane extraction and sign/zero extension, splits SH into two byte writes, and flags misaligned or out-of-range accesses without touching memory.

---
 rtl/lsu_mem_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the execute stage and the data RAM.
// Turns RV32I loads/stores into word reads, word writes and byte writes,
// extracts/extends load lanes, splits SH into two byte writes and reports
// misaligned or out-of-range accesses without touching memory.
module lsu_mem_ctrl #(
   parameter int unsigned MEM_BYTES = 524288
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_misaligned,
   output logic        resp_out_of_range,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_w_write_enable,
   output logic        mem_b_write_enable,
   output logic        mem_read_enable,
   output logic [2:0]  mem_funct3,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [2:0] {StIdle, StLoad, StStore0, StStore1, StResp} state_e;

   state_e      r_state;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic        r_resp_valid;
   logic        r_misaligned;
   logic        r_out_of_range;

   logic        w_illegal;
   logic        w_misaligned;
   logic        w_out_of_range;
   logic [32:0] w_size;
   logic [32:0] w_end;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_data;

   // Decode the incoming request: legality, alignment and 33-bit range check
   always_comb begin
      w_misaligned = 1'b0;
      w_size       = 33'd4;
      if (req_is_store) begin
         w_illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
      end else begin
         w_illegal = (req_funct3[1:0] == 2'b11) | (req_funct3 == 3'b110);
      end
      case (req_funct3[1:0])
         2'b00: w_size = 33'd1;
         2'b01: begin
            w_size       = 33'd2;
            w_misaligned = req_addr[0];
         end
         2'b10: w_misaligned = (req_addr[1:0] != 2'b00);
         default: w_size = 33'd4;
      endcase
      // Widened so addresses near 0xFFFFFFFF cannot wrap past the check
      w_end          = {1'b0, req_addr} + w_size;
      w_out_of_range = (w_end > 33'(MEM_BYTES));
   end

   // Select the addressed lane of the RAM word and extend it
   always_comb begin
      case (r_addr[1:0])
         2'b00:   w_byte = mem_read_data[7:0];
         2'b01:   w_byte = mem_read_data[15:8];
         2'b10:   w_byte = mem_read_data[23:16];
         default: w_byte = mem_read_data[31:24];
      endcase
      w_half = r_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];
      case (r_funct3)
         3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
         3'b010:  w_load_data = mem_read_data;
         3'b100:  w_load_data = {24'b0, w_byte};
         3'b101:  w_load_data = {16'b0, w_half};
         default: w_load_data = 32'b0;
      endcase
   end

   // Sequencer state and registered response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= StIdle;
         r_funct3       <= 3'b0;
         r_addr         <= 32'b0;
         r_wdata        <= 32'b0;
         r_rdata        <= 32'b0;
         r_resp_valid   <= 1'b0;
         r_misaligned   <= 1'b0;
         r_out_of_range <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (req_valid) begin
                  r_funct3       <= req_funct3;
                  r_addr         <= req_addr;
                  r_wdata        <= req_wdata;
                  r_rdata        <= 32'b0;
                  r_misaligned   <= 1'b0;
                  r_out_of_range <= 1'b0;
                  // Misalignment outranks the range fault
                  if (w_illegal || w_misaligned) begin
                     r_misaligned <= 1'b1;
                     r_resp_valid <= 1'b1;
                     r_state      <= StResp;
                  end else if (w_out_of_range) begin
                     r_out_of_range <= 1'b1;
                     r_resp_valid   <= 1'b1;
                     r_state        <= StResp;
                  end else if (req_is_store) begin
                     r_state <= StStore0;
                  end else begin
                     r_state <= StLoad;
                  end
               end
            end
            StLoad: begin
               r_rdata      <= w_load_data;
               r_resp_valid <= 1'b1;
               r_state      <= StResp;
            end
            StStore0: begin
               if (r_funct3 == 3'b001) begin
                  r_state <= StStore1;
               end else begin
                  r_resp_valid <= 1'b1;
                  r_state      <= StResp;
               end
            end
            StStore1: begin
               r_resp_valid <= 1'b1;
               r_state      <= StResp;
            end
            StResp: begin
               r_resp_valid <= 1'b0;
               r_state      <= StIdle;
            end
            default: begin
               r_resp_valid <= 1'b0;
               r_state      <= StIdle;
            end
         endcase
      end
   end

   // RAM command decode; reset gates every enable so no write lands in a reset cycle
   always_comb begin
      mem_address        = 32'b0;
      mem_write_data     = 32'b0;
      mem_w_write_enable = 1'b0;
      mem_b_write_enable = 1'b0;
      mem_read_enable    = 1'b0;
      mem_funct3         = 3'b000;
      if (!rst) begin
         case (r_state)
            StLoad: begin
               mem_read_enable = 1'b1;
               mem_funct3      = 3'b010;
               mem_address     = {r_addr[31:2], 2'b00};
            end
            StStore0: begin
               mem_address = r_addr;
               if (r_funct3 == 3'b010) begin
                  mem_w_write_enable = 1'b1;
                  mem_write_data     = r_wdata;
               end else begin
                  mem_b_write_enable = 1'b1;
                  mem_write_data     = {24'b0, r_wdata[7:0]};
               end
            end
            StStore1: begin
               mem_address        = r_addr + 32'd1;
               mem_b_write_enable = 1'b1;
               mem_write_data     = {24'b0, r_wdata[15:8]};
            end
            default: mem_address = 32'b0;
         endcase
      end
   end

   assign req_ready         = (r_state == StIdle);
   assign resp_valid        = r_resp_valid;
   assign resp_rdata        = r_rdata;
   assign resp_misaligned   = r_misaligned;
   assign resp_out_of_range = r_out_of_range;

endmodule
